// File: rtl/spdif_pkg.sv
// Shared constants and helpers for the S/PDIF transmitter.
package spdif_pkg;

    // Preamble cell patterns, first cell in bit 7, for a line level of 0
    // before the preamble. If the line level is 1 they are sent inverted.
    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    localparam int SLOTS_PER_FRAME = 64;
    localparam int CELLS_PER_SLOT  = 2;

    // Channel-status bit positions carried by this transmitter.
    localparam int CS_BYTE0_HI = 7;
    localparam int CS_FS_LO    = 24;
    localparam int CS_FS_HI    = 27;

    // Channel-status bit n of the block: byte 0 and the sample-rate code,
    // all other bits are 0.
    function automatic logic cs_bit(input logic [31:0] n, input logic [7:0] b0,
                                    input logic [3:0] fs);
        logic r;
        r = 1'b0;
        if (n <= 32'(CS_BYTE0_HI))
            r = b0[n[2:0]];
        else if (n >= 32'(CS_FS_LO) && n <= 32'(CS_FS_HI))
            r = fs[2'(n - 32'(CS_FS_LO))];
        return r;
    endfunction

endpackage

// File: rtl/spdif_bmc_cell.sv
// Biphase-mark cell generator: turns one slot-level bit (or a preamble
// pattern) into two line cells, tracking line level and cell phase.
module spdif_bmc_cell (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       cell_en,
    input  logic       bit_in,
    input  logic       pre_flag,
    input  logic [1:0] pre_cells,
    output logic       spdif_out,
    output logic       cell_phase
);
    // Line level seen just before the current preamble; preambles return
    // the line to this level, so it only follows data cells.
    logic ref_lvl;
    logic next_lvl;

    // Next line level for the coming cell.
    always_comb begin
        next_lvl = spdif_out;
        if (pre_flag)
            next_lvl = (cell_phase ? pre_cells[0] : pre_cells[1]) ^ ref_lvl;
        else if (!cell_phase)
            next_lvl = ~spdif_out;
        else if (bit_in)
            next_lvl = ~spdif_out;
    end

    // Line register, reference level and cell phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spdif_out  <= 1'b0;
            ref_lvl    <= 1'b0;
            cell_phase <= 1'b0;
        end else if (clear) begin
            spdif_out  <= 1'b0;
            ref_lvl    <= 1'b0;
            cell_phase <= 1'b0;
        end else if (cell_en) begin
            spdif_out  <= next_lvl;
            cell_phase <= ~cell_phase;
            if (!pre_flag)
                ref_lvl <= next_lvl;
        end
    end

endmodule

// File: rtl/spdif_transmitter.sv
// IEC 60958 consumer S/PDIF transmitter: framing counters, sample
// handshake, V/U/C/P generation; line coding is in spdif_bmc_cell.
module spdif_transmitter
    import spdif_pkg::*;
#(
    parameter int SAMPLE_W     = 24,
    parameter int BLOCK_FRAMES = 192
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tx_enable,
    input  logic                cell_en,
    input  logic [SAMPLE_W-1:0] left_in,
    input  logic [SAMPLE_W-1:0] right_in,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [7:0]          cs_byte0,
    input  logic [3:0]          cs_fs_code,
    output logic                spdif_out,
    output logic                block_start,
    output logic                underrun
);
    localparam int AW = 24;
    localparam int FW = $clog2(BLOCK_FRAMES);

    logic [5:0]          slot_cnt;
    logic [FW-1:0]       frame_cnt;
    logic                cell_phase;
    logic [4:0]          sub_slot;
    logic                right_sub;
    logic                adv;
    logic                load;
    logic                accept;
    logic                hold_full;
    logic [SAMPLE_W-1:0] hold_l;
    logic [SAMPLE_W-1:0] hold_r;
    logic [AW-1:0]       sh_l;
    logic [AW-1:0]       sh_r;
    logic                frame_valid;
    logic                parity;
    logic [7:0]          cs_b0_q;
    logic [3:0]          cs_fs_q;
    logic [AW-1:0]       cur_word;
    logic [4:0]          aud_idx;
    logic                slot_bit;
    logic                pre_flag;
    logic [7:0]          pre_pat;
    logic [1:0]          pre_cells;

    assign sub_slot  = slot_cnt[4:0];
    assign right_sub = slot_cnt[5];
    // Slot advances on the second cell of each slot.
    assign adv  = tx_enable && cell_en && (cell_phase == 1'(CELLS_PER_SLOT - 1));
    // Frame load on the first cell of a left subframe.
    assign load = tx_enable && cell_en && !cell_phase && (slot_cnt == 6'd0);

    // Handshake: a pair transfers on any clk where s_valid && s_ready;
    // s_ready is high exactly while the one-deep holding register is empty.
    assign s_ready = ~hold_full;
    assign accept  = s_valid && s_ready;

    // Slot-level bit for the current slot and the preamble cell pair.
    always_comb begin
        cur_word = right_sub ? sh_r : sh_l;
        aud_idx  = sub_slot - 5'd4;
        slot_bit = 1'b0;
        pre_flag = (sub_slot < 5'd4);
        if (right_sub)
            pre_pat = PRE_W;
        else if (frame_cnt == '0)
            pre_pat = PRE_B;
        else
            pre_pat = PRE_M;
        case (sub_slot[1:0])
            2'd0:    pre_cells = pre_pat[7:6];
            2'd1:    pre_cells = pre_pat[5:4];
            2'd2:    pre_cells = pre_pat[3:2];
            default: pre_cells = pre_pat[1:0];
        endcase
        if (sub_slot >= 5'd4 && sub_slot <= 5'd27)
            slot_bit = cur_word[aud_idx];
        else if (sub_slot == 5'd28)
            slot_bit = ~frame_valid;
        else if (sub_slot == 5'd30)
            slot_bit = cs_bit(32'(frame_cnt), cs_b0_q, cs_fs_q);
        else if (sub_slot == 5'd31)
            slot_bit = parity;
    end

    // Slot and frame counters, plus running parity over slots 4..30.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt  <= '0;
            frame_cnt <= '0;
            parity    <= 1'b0;
        end else if (!tx_enable) begin
            slot_cnt  <= '0;
            frame_cnt <= '0;
            parity    <= 1'b0;
        end else if (adv) begin
            slot_cnt <= slot_cnt + 6'd1;
            if (slot_cnt == 6'(SLOTS_PER_FRAME - 1))
                frame_cnt <= (frame_cnt == FW'(BLOCK_FRAMES - 1)) ? '0 : frame_cnt + FW'(1);
            parity <= pre_flag ? 1'b0 : (parity ^ slot_bit);
        end
    end

    // Holding register: a new transfer beats a simultaneous frame load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_l    <= left_in;
            hold_r    <= right_in;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // Frame load into the shift words, status pulses and cs capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_l        <= '0;
            sh_r        <= '0;
            frame_valid <= 1'b0;
            underrun    <= 1'b0;
            block_start <= 1'b0;
            cs_b0_q     <= '0;
            cs_fs_q     <= '0;
        end else if (!tx_enable) begin
            sh_l        <= '0;
            sh_r        <= '0;
            frame_valid <= 1'b0;
            underrun    <= 1'b0;
            block_start <= 1'b0;
        end else begin
            underrun    <= load && !hold_full;
            block_start <= load && (frame_cnt == '0);
            if (load) begin
                frame_valid <= hold_full;
                sh_l <= hold_full ? (AW'(hold_l) << (AW - SAMPLE_W)) : '0;
                sh_r <= hold_full ? (AW'(hold_r) << (AW - SAMPLE_W)) : '0;
                if (frame_cnt == '0) begin
                    cs_b0_q <= cs_byte0;
                    cs_fs_q <= cs_fs_code;
                end
            end
        end
    end

    spdif_bmc_cell u_bmc (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (!tx_enable),
        .cell_en    (cell_en),
        .bit_in     (slot_bit),
        .pre_flag   (pre_flag),
        .pre_cells  (pre_cells),
        .spdif_out  (spdif_out),
        .cell_phase (cell_phase)
    );

endmodule

// File: tb/tb_spdif_transmitter.sv
// Directed self-checking bench for spdif_transmitter: decodes the
// biphase-mark stream cell by cell and checks framing and data.
module tb_spdif_transmitter;

    localparam logic [7:0] B_PAT = 8'b11101000;
    localparam logic [7:0] M_PAT = 8'b11100010;
    localparam logic [7:0] W_PAT = 8'b11100100;

    logic        clk = 1'b0;
    logic        reset_n, tx_enable, cell_en, s_valid, s_ready;
    logic        spdif_out, block_start, underrun;
    logic [23:0] left_in, right_in;
    logic [7:0]  cs_byte0;
    logic [3:0]  cs_fs_code;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [23:0] exp_q[$];
    int          acc_cnt = 0;
    bit          auto_feed = 0;
    int          cell_no = 0;
    int          bs_cnt = 0, bs_last = -1, bs_prev = -1;
    int          ur_cnt = 0;
    int          fidx = 0;
    logic [191:0] cbits = '0;
    int          c_lr_err = 0;
    logic        last_lvl = 1'b0, lvl_pre0 = 1'b0, lvl_pre64 = 1'b0;

    spdif_transmitter #(.SAMPLE_W(24), .BLOCK_FRAMES(192)) dut (
        .clk(clk), .reset_n(reset_n), .tx_enable(tx_enable), .cell_en(cell_en),
        .left_in(left_in), .right_in(right_in), .s_valid(s_valid), .s_ready(s_ready),
        .cs_byte0(cs_byte0), .cs_fs_code(cs_fs_code), .spdif_out(spdif_out),
        .block_start(block_start), .underrun(underrun)
    );

    // clock
    always #5 clk = ~clk;

    // ---- decode helpers ----
    function automatic logic dbit(input logic [127:0] c, input int sub, input int slot);
        int i;
        i = sub * 64 + slot * 2;
        return c[i] ^ c[i + 1];
    endfunction

    function automatic logic [23:0] daud(input logic [127:0] c, input int sub);
        logic [23:0] r;
        for (int k = 0; k < 24; k++) r[k] = dbit(c, sub, 4 + k);
        return r;
    endfunction

    function automatic logic [7:0] dpre(input logic [127:0] c, input int base);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[7 - k] = c[base + k];
        return r;
    endfunction

    function automatic int bmc_err(input logic [127:0] c);
        int e;
        e = 0;
        for (int s = 0; s < 2; s++)
            for (int sl = 4; sl < 32; sl++)
                if (c[s * 64 + sl * 2] == c[s * 64 + sl * 2 - 1]) e++;
        return e;
    endfunction

    function automatic logic par_model(input logic [127:0] c, input int sub);
        logic p;
        p = 1'b0;
        for (int sl = 4; sl < 31; sl++) p = p ^ dbit(c, sub, sl);
        return p;
    endfunction

    function automatic logic [7:0] inv_if(input logic [7:0] p, input logic lvl);
        return lvl ? ~p : p;
    endfunction

    // ---- driver tasks ----
    // One clk; records a handshake transfer that the coming edge will make.
    task automatic step();
        bit acc;
        acc = (s_valid === 1'b1) && (s_ready === 1'b1);
        if (acc) begin
            exp_q.push_back(left_in);
            acc_cnt++;
        end
        @(negedge clk);
        if (acc && auto_feed) begin
            left_in  = left_in + 24'd1;
            right_in = ~left_in;
        end
    endtask

    task automatic do_cell(input int gap, output logic lvl);
        cell_en = 1'b1;
        step();
        cell_en = 1'b0;
        lvl = spdif_out;
        last_lvl = lvl;
        if (underrun === 1'b1) ur_cnt++;
        if (block_start === 1'b1) begin
            bs_cnt++;
            bs_prev = bs_last;
            bs_last = cell_no;
        end
        cell_no++;
        repeat (gap) step();
    endtask

    task automatic run_frame(input int gap, output logic [127:0] c);
        logic l;
        for (int i = 0; i < 128; i++) begin
            if (i == 0) lvl_pre0 = last_lvl;
            if (i == 64) lvl_pre64 = last_lvl;
            do_cell(gap, l);
            c[i] = l;
        end
        if (dbit(c, 0, 30) !== dbit(c, 1, 30)) c_lr_err++;
        cbits[fidx % 192] = dbit(c, 0, 30);
        fidx++;
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        left_in = l;
        right_in = r;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    // ---- tests ----
    task automatic test_reset();
        n_cmp++;
        if ({spdif_out, s_ready, block_start, underrun} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_outputs: got out/rdy/bs/ur=%b want 0100",
                     {spdif_out, s_ready, block_start, underrun});
        end
    endtask

    task automatic test_idle();
        logic [127:0] c;
        int ur0;
        ur0 = ur_cnt;
        run_frame(3, c);
        n_cmp++;
        if (dpre(c, 0) !== B_PAT) begin
            n_fail++; $display("FAIL idle_pre_b: got %b want %b", dpre(c, 0), B_PAT);
        end
        n_cmp++;
        if (dpre(c, 64) !== inv_if(W_PAT, lvl_pre64)) begin
            n_fail++; $display("FAIL idle_pre_w: got %b want %b", dpre(c, 64), inv_if(W_PAT, lvl_pre64));
        end
        n_cmp++;
        if (ur_cnt - ur0 !== 1) begin
            n_fail++; $display("FAIL idle_underrun: got %0d pulses want 1", ur_cnt - ur0);
        end
        n_cmp++;
        if (bs_cnt !== 1 || bs_last !== 0) begin
            n_fail++; $display("FAIL idle_block_start: got cnt %0d at cell %0d want 1 at 0", bs_cnt, bs_last);
        end
        n_cmp++;
        if ({daud(c, 0), daud(c, 1)} !== 48'h0) begin
            n_fail++; $display("FAIL idle_audio: got %h want 0", {daud(c, 0), daud(c, 1)});
        end
        n_cmp++;
        if ({dbit(c, 0, 28), dbit(c, 1, 28), dbit(c, 0, 29), dbit(c, 0, 31), dbit(c, 1, 31)} !== 5'b11011) begin
            n_fail++; $display("FAIL idle_vup: got V/V/U/P/P=%b want 11011",
                               {dbit(c, 0, 28), dbit(c, 1, 28), dbit(c, 0, 29), dbit(c, 0, 31), dbit(c, 1, 31)});
        end
        n_cmp++;
        if (bmc_err(c) !== 0) begin
            n_fail++; $display("FAIL idle_bmc: got %0d missing bit-start transitions want 0", bmc_err(c));
        end
        run_frame(3, c);
        n_cmp++;
        if (dpre(c, 0) !== inv_if(M_PAT, lvl_pre0) || ur_cnt - ur0 !== 2) begin
            n_fail++; $display("FAIL idle_pre_m: got %b ur %0d want %b ur 2",
                               dpre(c, 0), ur_cnt - ur0, inv_if(M_PAT, lvl_pre0));
        end
    endtask

    task automatic test_audio();
        logic [127:0] c;
        logic [23:0] junk;
        int ur0;
        run_frame(3, c);
        push(24'h000001, 24'h800000);
        n_cmp++;
        if (s_ready !== 1'b0) begin
            n_fail++; $display("FAIL audio_ready_low: got %b want 0", s_ready);
        end
        ur0 = ur_cnt;
        run_frame(3, c);
        if (exp_q.size() > 0) junk = exp_q.pop_front();
        n_cmp++;
        if ({daud(c, 0), daud(c, 1)} !== {24'h000001, 24'h800000}) begin
            n_fail++; $display("FAIL audio_data: got %h %h want 000001 800000", daud(c, 0), daud(c, 1));
        end
        n_cmp++;
        if ({dbit(c, 0, 28), dbit(c, 1, 28), dbit(c, 0, 31), dbit(c, 1, 31)} !== 4'b0011) begin
            n_fail++; $display("FAIL audio_vp: got V/V/P/P=%b want 0011",
                               {dbit(c, 0, 28), dbit(c, 1, 28), dbit(c, 0, 31), dbit(c, 1, 31)});
        end
        n_cmp++;
        if (ur_cnt != ur0 || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL audio_load: got ur %0d ready %b want 0 1", ur_cnt - ur0, s_ready);
        end
    endtask

    task automatic test_cs_block();
        logic [127:0] c;
        logic [191:0] exp_c;
        int pre_err;
        pre_err = 0;
        while (fidx < 192) begin
            run_frame(0, c);
            if (dpre(c, 0) !== inv_if(M_PAT, lvl_pre0)) pre_err++;
            if (dpre(c, 64) !== inv_if(W_PAT, lvl_pre64)) pre_err++;
            if (par_model(c, 0) !== dbit(c, 0, 31) || par_model(c, 1) !== dbit(c, 1, 31)) pre_err++;
        end
        exp_c = '0;
        exp_c[2] = 1'b1;
        exp_c[25] = 1'b1;
        n_cmp++;
        if (cbits !== exp_c || c_lr_err !== 0) begin
            n_fail++; $display("FAIL cs_stream: got %h (lr_err %0d) want %h", cbits, c_lr_err, exp_c);
        end
        run_frame(0, c);
        if (dpre(c, 0) !== inv_if(B_PAT, lvl_pre0)) pre_err++;
        n_cmp++;
        if (pre_err !== 0) begin
            n_fail++; $display("FAIL cs_frames: got %0d preamble/parity errors want 0", pre_err);
        end
        n_cmp++;
        if (bs_cnt !== 2 || bs_last - bs_prev !== 24576) begin
            n_fail++; $display("FAIL block_period: got cnt %0d period %0d want 2 24576", bs_cnt, bs_last - bs_prev);
        end
        n_cmp++;
        if (ur_cnt !== 192) begin
            n_fail++; $display("FAIL block_underruns: got %0d want 192", ur_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] c;
        logic [23:0] exp, prev;
        int ur0, acc0;
        ur0 = ur_cnt;
        acc0 = acc_cnt;
        left_in = 24'h000100;
        right_in = ~24'h000100;
        s_valid = 1'b1;
        auto_feed = 1'b1;
        run_frame(3, c);
        n_cmp++;
        if (ur_cnt - ur0 !== 1 || acc_cnt - acc0 !== 1 || s_ready !== 1'b0 || dbit(c, 0, 28) !== 1'b1) begin
            n_fail++; $display("FAIL b2b_simultaneous: got ur %0d acc %0d rdy %b V %b want 1 1 0 1",
                               ur_cnt - ur0, acc_cnt - acc0, s_ready, dbit(c, 0, 28));
        end
        prev = 24'h0000FF;
        for (int f = 0; f < 10; f++) begin
            run_frame(3, c);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL b2b_queue: frame %0d got empty queue want a sample", f);
            end else begin
                exp = exp_q.pop_front();
                if ({daud(c, 0), daud(c, 1), dbit(c, 0, 28)} !== {exp, ~exp, 1'b0}) begin
                    n_fail++; $display("FAIL b2b_data: frame %0d got %h %h V%b want %h %h V0",
                                       f, daud(c, 0), daud(c, 1), dbit(c, 0, 28), exp, ~exp);
                end
            end
            n_cmp++;
            if (daud(c, 0) !== prev + 24'd1) begin
                n_fail++; $display("FAIL b2b_sequence: frame %0d got %h want %h", f, daud(c, 0), prev + 24'd1);
            end
            prev = daud(c, 0);
        end
        s_valid = 1'b0;
        auto_feed = 1'b0;
        n_cmp++;
        if (acc_cnt - acc0 !== 11 || exp_q.size() !== 1) begin
            n_fail++; $display("FAIL b2b_accepts: got %0d accepts, %0d pending want 11, 1",
                               acc_cnt - acc0, exp_q.size());
        end
    endtask

    task automatic test_disable();
        logic [127:0] c;
        logic l;
        int hi, ur0, f0;
        for (int i = 0; i < 31; i++) do_cell(3, l);
        exp_q.delete();
        tx_enable = 1'b0;
        step();
        n_cmp++;
        if (spdif_out !== 1'b0) begin
            n_fail++; $display("FAIL dis_out: got %b want 0", spdif_out);
        end
        hi = 0;
        ur0 = ur_cnt;
        for (int i = 0; i < 20; i++) begin
            do_cell(3, l);
            if (l !== 1'b0) hi++;
        end
        n_cmp++;
        if (hi !== 0 || ur_cnt !== ur0) begin
            n_fail++; $display("FAIL dis_idle: got %0d high cells, %0d underruns want 0 0", hi, ur_cnt - ur0);
        end
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_fail++; $display("FAIL dis_ready: got %b want 1", s_ready);
        end
        push(24'h0ABCDE, 24'h123456);
        n_cmp++;
        if (s_ready !== 1'b0) begin
            n_fail++; $display("FAIL dis_accept: got ready %b want 0", s_ready);
        end
        exp_q.delete();
        tx_enable = 1'b1;
        step();
        f0 = cell_no;
        run_frame(3, c);
        n_cmp++;
        if (dpre(c, 0) !== B_PAT || bs_last !== f0) begin
            n_fail++; $display("FAIL reen_pre: got %b bs@%0d want %b bs@%0d", dpre(c, 0), bs_last, B_PAT, f0);
        end
        n_cmp++;
        if ({daud(c, 0), daud(c, 1), dbit(c, 0, 28)} !== {24'h0ABCDE, 24'h123456, 1'b0}) begin
            n_fail++; $display("FAIL reen_data: got %h %h V%b want 0abcde 123456 V0",
                               daud(c, 0), daud(c, 1), dbit(c, 0, 28));
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] c;
        logic l;
        int ur0, f0;
        for (int i = 0; i < 84; i++) do_cell(3, l);
        push(24'h00FACE, 24'h00BEEF);
        n_cmp++;
        if (s_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_pre_ready: got %b want 0", s_ready);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({spdif_out, s_ready, block_start, underrun} !== 4'b0100) begin
            n_fail++; $display("FAIL rst_async: got out/rdy/bs/ur=%b want 0100",
                               {spdif_out, s_ready, block_start, underrun});
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        last_lvl = 1'b0;
        step();
        ur0 = ur_cnt;
        f0 = cell_no;
        run_frame(3, c);
        n_cmp++;
        if (dpre(c, 0) !== B_PAT || bs_last !== f0) begin
            n_fail++; $display("FAIL rst_restart: got %b bs@%0d want %b bs@%0d", dpre(c, 0), bs_last, B_PAT, f0);
        end
        n_cmp++;
        if (ur_cnt - ur0 !== 1 || dbit(c, 0, 28) !== 1'b1 || daud(c, 0) !== 24'h0) begin
            n_fail++; $display("FAIL rst_empty: got ur %0d V %b L %h want 1 1 000000",
                               ur_cnt - ur0, dbit(c, 0, 28), daud(c, 0));
        end
    endtask

    // ---- sequence ----
    initial begin
        reset_n = 1'b0;
        tx_enable = 1'b0;
        cell_en = 1'b0;
        s_valid = 1'b0;
        left_in = '0;
        right_in = '0;
        cs_byte0 = 8'h04;
        cs_fs_code = 4'h2;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        tx_enable = 1'b1;
        step();
        test_idle();
        test_audio();
        test_cs_block();
        test_back_to_back();
        test_disable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
